// File: rtl/fp_round_pack_sp.sv
// Normalize, round-to-nearest-even and pack stage for single-precision divider results.
// One operation in flight; valid/ready handshake on both sides, all outputs registered.
module fp_round_pack_sp #(
    parameter int EXP_W        = 10,
    parameter int MAX_DN_SHIFT = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic             i_sign,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [26:0]      i_mant,
    input  logic [1:0]       i_special,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [31:0]      o_z,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_inexact
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NORM   = 3'd1;
    localparam logic [2:0] S_DENORM = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    localparam logic signed [EXP_W:0] C_ZERO    = '0;
    localparam logic signed [EXP_W:0] C_ONE     = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] C_BIAS    = (EXP_W+1)'(127);
    localparam logic signed [EXP_W:0] C_EXP_MAX = (EXP_W+1)'(255);
    localparam logic signed [EXP_W:0] C_MAX_DN  = (EXP_W+1)'(MAX_DN_SHIFT);

    logic [2:0]              r_state;
    logic                    r_sign;
    logic signed [EXP_W:0]   r_exp;      // unbiased in S_NORM, biased afterwards
    logic [26:0]             r_mant;
    logic                    r_tiny;
    logic [31:0]             r_res_z;
    logic                    r_res_ovf;
    logic                    r_res_unf;
    logic                    r_res_inx;
    logic                    r_in_ready;
    logic                    r_valid;
    logic [31:0]             r_z;
    logic                    r_ovf;
    logic                    r_unf;
    logic                    r_inx;

    logic signed [EXP_W:0]   w_be;
    logic signed [EXP_W:0]   w_dn_amt;
    logic                    w_inc;
    logic                    w_inexact;
    logic [24:0]             w_sum;
    logic                    w_carry;
    logic                    w_hidden;
    logic [22:0]             w_frac;
    logic signed [EXP_W:0]   w_rnd_be;

    assign w_be      = r_exp + C_BIAS;
    assign w_dn_amt  = C_ONE - r_exp;
    assign w_inc     = r_mant[2] & (r_mant[1] | r_mant[0] | r_mant[3]);
    assign w_inexact = |r_mant[2:0];
    // Rounding only touches bits [26:3]; a carry into bit 24 here is a carry out of mantissa bit 26.
    assign w_sum     = {1'b0, r_mant[26:3]} + 25'(w_inc);
    assign w_carry   = w_sum[24];
    assign w_hidden  = w_sum[24] | w_sum[23];
    assign w_frac    = w_carry ? w_sum[23:1] : w_sum[22:0];
    assign w_rnd_be  = w_carry ? r_exp + C_ONE : r_exp;

    // NOTE: sequential state uses non-blocking assignments only, so every branch sees start-of-cycle values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_tiny     <= 1'b0;
            r_res_z    <= '0;
            r_res_ovf  <= 1'b0;
            r_res_unf  <= 1'b0;
            r_res_inx  <= 1'b0;
            r_in_ready <= 1'b1;
            r_valid    <= 1'b0;
            r_z        <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inx      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= i_sign;
                        r_exp      <= {i_exp[EXP_W-1], i_exp};
                        r_mant     <= i_mant;
                        r_tiny     <= 1'b0;
                        r_res_ovf  <= 1'b0;
                        r_res_unf  <= 1'b0;
                        r_res_inx  <= 1'b0;
                        case (i_special)
                            2'b00: r_state <= S_NORM;
                            2'b01: begin
                                r_res_z <= {i_sign, 31'b0};
                                r_state <= S_OUT;
                            end
                            2'b10: begin
                                r_res_z <= {i_sign, 8'hFF, 23'b0};
                                r_state <= S_OUT;
                            end
                            default: begin
                                r_res_z <= 32'h7FC0_0000;
                                r_state <= S_OUT;
                            end
                        endcase
                    end
                end
                S_NORM: begin
                    if (r_mant == 27'd0) begin
                        r_res_z <= {r_sign, 31'b0};
                        r_state <= S_OUT;
                    end else if (!r_mant[26]) begin
                        r_mant <= {r_mant[25:0], 1'b0};
                        r_exp  <= r_exp - C_ONE;
                    end else begin
                        r_exp <= w_be;
                        if (w_be >= C_EXP_MAX) begin
                            r_res_z   <= {r_sign, 8'hFF, 23'b0};
                            r_res_ovf <= 1'b1;
                            r_res_inx <= 1'b1;
                            r_state   <= S_OUT;
                        end else if (w_be <= C_ZERO) begin
                            r_tiny  <= 1'b1;
                            r_state <= S_DENORM;
                        end else begin
                            r_state <= S_ROUND;
                        end
                    end
                end
                S_DENORM: begin
                    // Shifting beyond the mantissa width leaves only sticky, so collapse at once.
                    if (w_dn_amt > C_MAX_DN) begin
                        r_mant  <= {26'b0, |r_mant};
                        r_exp   <= C_ONE;
                        r_state <= S_ROUND;
                    end else begin
                        r_mant <= {1'b0, r_mant[26:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + C_ONE;
                        if (r_exp == C_ZERO) begin
                            r_state <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    r_res_inx <= w_inexact;
                    r_res_unf <= r_tiny & w_inexact;
                    if (w_rnd_be >= C_EXP_MAX) begin
                        r_res_z   <= {r_sign, 8'hFF, 23'b0};
                        r_res_ovf <= 1'b1;
                    end else begin
                        r_res_z <= {r_sign, (w_hidden ? w_rnd_be[7:0] : 8'h00), w_frac};
                    end
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_z     <= r_res_z;
                        r_ovf   <= r_res_ovf;
                        r_unf   <= r_res_unf;
                        r_inx   <= r_res_inx;
                    end else if (i_out_ready) begin
                        r_valid    <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_valid    <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_valid     = r_valid;
    assign o_z         = r_z;
    assign o_overflow  = r_ovf;
    assign o_underflow = r_unf;
    assign o_inexact   = r_inx;
endmodule

// File: tb/tb_fp_round_pack_sp.sv
// Directed-vector bench for fp_round_pack_sp: packing, RNE rounding, normalize,
// overflow, subnormals, specials, output back-pressure and reset during denormalization.
module tb_fp_round_pack_sp;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_in_ready;
    logic        i_sign;
    logic [9:0]  i_exp;
    logic [26:0] i_mant;
    logic [1:0]  i_special;
    logic        o_valid;
    logic        i_out_ready;
    logic [31:0] o_z;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_inexact;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [26:0] m;
        logic [1:0]  sp;
        logic [31:0] z;
        logic [2:0]  fl;   // {overflow, underflow, inexact}
        logic [7:0]  lat;
    } vec_t;

    always #5 clk = ~clk;

    fp_round_pack_sp #(.EXP_W(10), .MAX_DN_SHIFT(26)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .o_in_ready (o_in_ready),
        .i_sign     (i_sign),
        .i_exp      (i_exp),
        .i_mant     (i_mant),
        .i_special  (i_special),
        .o_valid    (o_valid),
        .i_out_ready(i_out_ready),
        .o_z        (o_z),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow),
        .o_inexact  (o_inexact)
    );

    // Drive one operation, measure edges from accept to o_valid, then complete the handshake.
    task automatic run_op(input vec_t v, output logic [31:0] z, output logic [2:0] fl, output int lat);
        i_sign = v.s; i_exp = v.e; i_mant = v.m; i_special = v.sp; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        z  = o_z;
        fl = {o_overflow, o_underflow, o_inexact};
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (o_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", o_in_ready); end
        n_tests++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        n_tests++;
        if (o_z !== 32'h0) begin n_fail++; $display("FAIL reset_z: got %h expected 00000000", o_z); end
        n_tests++;
        if ({o_overflow, o_underflow, o_inexact} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {o_overflow, o_underflow, o_inexact});
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors(input string name, input vec_t v [], input int n);
        logic [31:0] z;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < n; i++) begin
            run_op(v[i], z, fl, lat);
            n_tests++;
            if (z !== v[i].z) begin n_fail++; $display("FAIL %s[%0d]_z: got %h expected %h", name, i, z, v[i].z); end
            n_tests++;
            if (fl !== v[i].fl) begin n_fail++; $display("FAIL %s[%0d]_flags: got %b expected %b", name, i, fl, v[i].fl); end
            n_tests++;
            if (lat !== int'(v[i].lat)) begin n_fail++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", name, i, lat, v[i].lat); end
        end
    endtask

    task automatic test_basic_pack();
        vec_t v [] = new[2];
        v[0] = '{s:1'b0, e:10'd0, m:27'h4000000, sp:2'b00, z:32'h3F80_0000, fl:3'b000, lat:8'd3};
        v[1] = '{s:1'b1, e:10'd0, m:27'h4000000, sp:2'b00, z:32'hBF80_0000, fl:3'b000, lat:8'd3};
        test_vectors("basic", v, 2);
    endtask

    task automatic test_rounding();
        vec_t v [] = new[3];
        v[0] = '{s:1'b0, e:10'd0, m:27'h4000004, sp:2'b00, z:32'h3F80_0000, fl:3'b001, lat:8'd3};
        v[1] = '{s:1'b0, e:10'd0, m:27'h400000C, sp:2'b00, z:32'h3F80_0002, fl:3'b001, lat:8'd3};
        v[2] = '{s:1'b0, e:10'd0, m:27'h7FFFFFC, sp:2'b00, z:32'h4000_0000, fl:3'b001, lat:8'd3};
        test_vectors("round", v, 3);
    endtask

    task automatic test_normalize_overflow();
        vec_t v [] = new[4];
        v[0] = '{s:1'b0, e:10'd1,   m:27'h2000000, sp:2'b00, z:32'h3F80_0000, fl:3'b000, lat:8'd4};
        v[1] = '{s:1'b0, e:10'd128, m:27'h4000000, sp:2'b00, z:32'h7F80_0000, fl:3'b101, lat:8'd2};
        v[2] = '{s:1'b1, e:10'd127, m:27'h7FFFFFC, sp:2'b00, z:32'hFF80_0000, fl:3'b101, lat:8'd3};
        v[3] = '{s:1'b1, e:10'd5,   m:27'h0000000, sp:2'b00, z:32'h8000_0000, fl:3'b000, lat:8'd2};
        test_vectors("norm_ovf", v, 4);
    endtask

    task automatic test_subnormal();
        vec_t v [] = new[4];
        v[0] = '{s:1'b0, e:10'(-127), m:27'h4000000, sp:2'b00, z:32'h0040_0000, fl:3'b000, lat:8'd4};
        v[1] = '{s:1'b0, e:10'(-150), m:27'h4000000, sp:2'b00, z:32'h0000_0000, fl:3'b011, lat:8'd27};
        v[2] = '{s:1'b0, e:10'(-400), m:27'h4000000, sp:2'b00, z:32'h0000_0000, fl:3'b011, lat:8'd4};
        v[3] = '{s:1'b0, e:10'(-127), m:27'h7FFFFFC, sp:2'b00, z:32'h0080_0000, fl:3'b011, lat:8'd4};
        test_vectors("subnorm", v, 4);
    endtask

    task automatic test_specials();
        vec_t v [] = new[3];
        v[0] = '{s:1'b1, e:10'd3, m:27'h4000000, sp:2'b11, z:32'h7FC0_0000, fl:3'b000, lat:8'd1};
        v[1] = '{s:1'b1, e:10'd3, m:27'h4000000, sp:2'b10, z:32'hFF80_0000, fl:3'b000, lat:8'd1};
        v[2] = '{s:1'b1, e:10'd3, m:27'h4000000, sp:2'b01, z:32'h8000_0000, fl:3'b000, lat:8'd1};
        test_vectors("special", v, 3);
    endtask

    task automatic test_hold();
        int lat = 0;
        i_sign = 1'b0; i_exp = 10'd0; i_mant = 27'h400000C; i_special = 2'b00; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        while (o_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== 3) begin n_fail++; $display("FAIL hold_latency: got %0d expected 3", lat); end
        // A new request while busy must be ignored.
        i_valid = 1'b1; i_sign = 1'b1; i_special = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_z !== 32'h3F80_0002 || o_valid !== 1'b1 || o_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got z=%h valid=%b in_ready=%b expected z=3f800002 valid=1 in_ready=0",
                         c, o_z, o_valid, o_in_ready);
            end
        end
        i_valid = 1'b0;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_out_ready = 1'b0;
        n_tests++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL hold_release: got valid=%b in_ready=%b expected valid=0 in_ready=1", o_valid, o_in_ready);
        end
    endtask

    task automatic test_reset_mid_denorm();
        vec_t v [] = new[1];
        i_sign = 1'b0; i_exp = 10'(-150); i_mant = 27'h4000000; i_special = 2'b00; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b0) begin
            n_fail++; $display("FAIL busy_denorm: got valid=%b in_ready=%b expected valid=0 in_ready=0", o_valid, o_in_ready);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        n_tests++;
        if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_z !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_denorm: got valid=%b in_ready=%b z=%h expected valid=0 in_ready=1 z=00000000",
                     o_valid, o_in_ready, o_z);
        end
        v[0] = '{s:1'b0, e:10'd0, m:27'h4000000, sp:2'b00, z:32'h3F80_0000, fl:3'b000, lat:8'd3};
        test_vectors("after_reset", v, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_mant = '0; i_special = '0; i_out_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic_pack();
        test_rounding();
        test_normalize_overflow();
        test_subnormal();
        test_specials();
        test_hold();
        test_reset_mid_denorm();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_round_pack_sp.md
Name: fp_round_pack_sp

Overview:
Post-divide normalize/round/pack stage for single-precision results. Sits directly downstream of the single-precision divider core. Accepts an unpacked quotient (sign, unbiased exponent, 27-bit mantissa carrying guard/round/sticky bits, special-case code) and produces an IEEE-754 binary32 word with round-to-nearest-even, subnormal handling and exception flags. Uses a valid/ready handshake on both sides.

Parameters:
EXP_W, 10, width of signed two's-complement unbiased input exponent
MAX_DN_SHIFT, 26, maximum right shifts in denormalization before full collapse into sticky

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low; sampled on clk
i_valid  input  1  upstream result valid
o_in_ready  output  1  block can accept an input
i_sign  input  1  result sign
i_exp  input  EXP_W  unbiased exponent, signed two's complement
i_mant  input  27  [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky
i_special  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
o_valid  output  1  o_z and flags valid
i_out_ready  input  1  downstream accepts output
o_z  output  32  packed binary32 result
o_overflow  output  1  overflow flag
o_underflow  output  1  underflow flag (tiny and inexact)
o_inexact  output  1  inexact flag

Behaviour:
- Reset (reset==0 at edge): state S_IDLE, o_in_ready=1, o_valid=0, o_z=0, all flags 0. Reset wins over any in-flight operation; partial work is discarded.
- All outputs are registered. o_in_ready=1 only in S_IDLE.
- S_IDLE: when i_valid&o_in_ready, capture all inputs and drop o_in_ready. Special codes go straight to S_OUT. Normal codes go to S_NORM.
- Special packing: zero gives {sign,31'b0}. Infinity gives {sign,8'hFF,23'b0}. NaN gives 0x7FC00000 with sign forced 0. Flags are 0 for all specials.
- S_NORM:
  - If mant==0, the result is signed zero and the next state is S_OUT.
  - If mant[26]==0, shift mant left 1 and decrement exp, one bit per cycle. Stay in S_NORM.
  - Once mant[26]==1, form biased exponent be = exp+127 (EXP_W+1 bits signed).
  - be>=255: go to S_OUT with {sign,8'hFF,0} and overflow=inexact=1.
  - be<=0: go to S_DENORM.
  - Otherwise: go to S_ROUND.
- S_DENORM:
  - Each cycle, shift mant right 1, OR the bit shifted out into mant[0], and be+=1. Leave when be==1; the exponent field becomes 0 if mant[26]==0 after rounding.
  - If 1-be > MAX_DN_SHIFT on entry, collapse in one cycle: mant = {26'b0, |mant}, be=1.
  - The tiny flag is set on entry.
- S_ROUND (1 cycle):
  - lsb=mant[3], G=mant[2], inc = G & (mant[1] | mant[0] | lsb).
  - inexact = |mant[2:0].
  - Add inc at bit 3.
  - If the add carries out of bit 26, shift right 1 and increment be. If be then reaches 255, the result is infinity and overflow=1.
  - A subnormal whose rounding sets bit 26 becomes normal with exponent field 1.
  - Exponent field = mant[26] ? be[7:0] : 0. Fraction = mant[25:3].
  - underflow = tiny & inexact.
- S_OUT: o_valid=1. o_z and flags stay stable until i_out_ready=1 at an edge. Then o_valid=0, o_in_ready=1, and the state returns to S_IDLE.
- Latency: for a pre-normalized normal input accepted at edge k, o_valid rises after edge k+3. Each extra normalize or denormalize shift adds 1 cycle. Specials are valid after edge k+1.
- Throughput: one operation in flight; no new acceptance until the output handshake completes.
- i_valid while busy is ignored; upstream holds it.

Test Plan:
1. Basic pack: i_sign=0, i_exp=0, i_mant=0x4000000 -> o_z=0x3F800000, flags 000, o_valid 3 cycles after accept.
2. RNE rounding:
   - Tie with even LSB: i_mant=0x4000004 -> 0x3F800000, inexact=1.
   - Odd LSB with guard: i_mant=0x400000C -> 0x3F800002.
   - Round carry-out: i_mant=0x7FFFFFC, i_exp=0 -> 0x40000000.
3. Normalize and overflow:
   - i_mant=0x2000000, i_exp=1 -> 0x3F800000 after 1 extra cycle.
   - i_exp=128, i_mant=0x4000000 -> 0x7F800000, overflow=1, inexact=1.
4. Subnormal:
   - i_exp=-127, i_mant=0x4000000 -> 0x00400000, underflow=0.
   - i_exp=-150, i_mant=0x4000000 -> 0x00000000, underflow=1, inexact=1.
   - i_exp=-400 -> collapse path, result 0x00000000, underflow=1.
5. Specials:
   - i_special=11 with i_sign=1 -> 0x7FC00000.
   - i_special=10, i_sign=1 -> 0xFF800000.
   - i_special=01, i_sign=1 -> 0x80000000.
   - All three valid 1 cycle after accept.
6. Handshake/reset:
   - Hold i_out_ready=0 for 5 cycles: o_z stable, o_valid=1, o_in_ready=0.
   - Assert reset=0 mid-S_DENORM: next edge o_valid=0, o_in_ready=1, o_z=0.
